// File: rtl/mmio_port_unit.sv
`default_nettype none
// ============================================================================
// Module   : mmio_port_unit
// Purpose  : Memory-mapped I/O responder on the MEM-stage data bus. It sits in
//            parallel with data_memory and answers loads/stores that fall in a
//            32-byte window at BASE_ADDR. It provides a 32-bit output port, a
//            synchronised and change-detected 8-bit input port, and a byte TX
//            FIFO drained over a valid/ready handshake.
//
// Register map (byte offset, decoded from address[4:2]):
//   0x00 PORT_OUT  RW  full 32-bit output port
//   0x04 PORT_IN   RO  {24'b0, in_sync}
//   0x08 STATUS    RW  [3:0] = {ovf, empty, full, chg}; ovf/chg are W1C
//   0x0C TX_DATA   WO  store pushes in_data[7:0]; loads return 0
//   0x10 IRQ_EN    RW  [1:0] = {ovf_en, chg_en} (only with MMIO_IRQ_EN)
//
// Ports:
//   clk           single clock, rising edge
//   reset         asynchronous, active-low reset
//   read_enable   MEM-stage load strobe
//   write_enable  MEM-stage store strobe
//   address       byte address
//   in_data       store data
//   out_data      combinational load data
//   hit           combinational window match
//   PortIn        asynchronous external input pins
//   PortOut       registered output port
//   tx_data       FIFO head byte (0 when empty)
//   tx_valid      FIFO non-empty
//   tx_ready      consumer accepts head
//   irq           interrupt request
//
// Configuration macro:
//   MMIO_IRQ_EN   when defined, adds the IRQ_EN register and a registered irq;
//                 otherwise offset 0x10 is unused and irq is tied low.
//
// Revision : 1.0 - initial release
// ============================================================================
module mmio_port_unit #(
    parameter logic [31:0] BASE_ADDR  = 32'h1001_FF00,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [31:0] address,
    input  logic [31:0] in_data,
    output logic [31:0] out_data,
    output logic        hit,
    input  logic [7:0]  PortIn,
    output logic [31:0] PortOut,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0]  OFF_PORT_OUT = 3'd0;
    localparam logic [2:0]  OFF_PORT_IN  = 3'd1;
    localparam logic [2:0]  OFF_STATUS   = 3'd2;
    localparam logic [2:0]  OFF_TX_DATA  = 3'd3;
`ifdef MMIO_IRQ_EN
    localparam logic [2:0]  OFF_IRQ_EN   = 3'd4;
`endif
    localparam logic [AW:0] PTR_ONE      = {{AW{1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [2:0] reg_off;
    logic       wr_hit;

    assign hit     = (address[31:5] == BASE_ADDR[31:5]);
    assign reg_off = address[4:2];
    assign wr_hit  = hit & write_enable;

    // Byte lane bits are ignored and loads carry no side effects, so the
    // load strobe does not participate in any state update.
    logic w_unused;
    assign w_unused = &{1'b0, address[1:0], read_enable};

    logic wr_port_out;
    logic wr_status;
    logic push_req;

    assign wr_port_out = wr_hit & (reg_off == OFF_PORT_OUT);
    assign wr_status   = wr_hit & (reg_off == OFF_STATUS);
    assign push_req    = wr_hit & (reg_off == OFF_TX_DATA);

    // ------------------------------------------------------------------
    // Output port
    // ------------------------------------------------------------------
    logic [31:0] port_out_q;
    logic [31:0] port_out_d;

    always_comb begin
        port_out_d = port_out_q;
        if (wr_port_out) begin
            port_out_d = in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            port_out_q <= 32'd0;
        end else begin
            port_out_q <= port_out_d;
        end
    end

    assign PortOut = port_out_q;

    // ------------------------------------------------------------------
    // Input port: two-flop synchroniser plus a history register for
    // change detection.
    // ------------------------------------------------------------------
    logic [7:0] sync1_q;
    logic [7:0] sync2_q;
    logic [7:0] prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 8'd0;
            sync2_q <= 8'd0;
            prev_q  <= 8'd0;
        end else begin
            sync1_q <= PortIn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO: circular buffer, pointers carry one extra wrap bit.
    // ------------------------------------------------------------------
    logic [AW:0] wr_ptr_q;
    logic [AW:0] wr_ptr_d;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] rd_ptr_d;
    logic [7:0]  fifo_mem_q [FIFO_DEPTH];

    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push_ok;
    logic push_drop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = ~fifo_empty & tx_ready;
    // A push into a full FIFO still fits if the head leaves on the same edge.
    assign push_ok    = push_req & (~fifo_full | pop);
    assign push_drop  = push_req & ~push_ok;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: tx_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= in_data[7:0];
        end
    end

    assign tx_valid = ~fifo_empty;
    assign tx_data  = fifo_empty ? 8'd0 : fifo_mem_q[rd_ptr_q[AW-1:0]];

    // ------------------------------------------------------------------
    // Sticky status bits. The set term is applied after the W1C clear so
    // that a new event is never lost to a coincident clear.
    // ------------------------------------------------------------------
    logic chg_q;
    logic chg_d;
    logic ovf_q;
    logic ovf_d;

    always_comb begin
        chg_d = chg_q;
        ovf_d = ovf_q;
        if (wr_status && in_data[0]) begin
            chg_d = 1'b0;
        end
        if (wr_status && in_data[3]) begin
            ovf_d = 1'b0;
        end
        if (sync2_q != prev_q) begin
            chg_d = 1'b1;
        end
        if (push_drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chg_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            chg_q <= chg_d;
            ovf_q <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt
    // ------------------------------------------------------------------
`ifdef MMIO_IRQ_EN
    logic [1:0] irq_en_q;
    logic [1:0] irq_en_d;
    logic       irq_q;
    logic       irq_d;

    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_hit && (reg_off == OFF_IRQ_EN)) begin
            irq_en_d = in_data[1:0];
        end
        irq_d = (chg_q & irq_en_q[0]) | (ovf_q & irq_en_q[1]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_en_q <= 2'b00;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Load data: reflects current (pre-write) state.
    // ------------------------------------------------------------------
    logic [31:0] rdata;

    always_comb begin
        rdata = 32'd0;
        case (reg_off)
            OFF_PORT_OUT: rdata = port_out_q;
            OFF_PORT_IN:  rdata = {24'd0, sync2_q};
            OFF_STATUS:   rdata = {28'd0, ovf_q, fifo_empty, fifo_full, chg_q};
`ifdef MMIO_IRQ_EN
            OFF_IRQ_EN:   rdata = {30'd0, irq_en_q};
`endif
            default:      rdata = 32'd0;
        endcase
    end

    assign out_data = hit ? rdata : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mmio_port_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_port_unit
// Purpose  : Self-checking bench for mmio_port_unit. TX bytes are tracked in a
//            scoreboard queue filled as pushes are driven and drained as the
//            DUT hands bytes out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_port_unit;

    localparam logic [31:0] BASE  = 32'h1001_FF00;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_enable;
    logic        write_enable;
    logic [31:0] address;
    logic [31:0] in_data;
    logic [31:0] out_data;
    logic        hit;
    logic [7:0]  PortIn;
    logic [31:0] PortOut;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;

    mmio_port_unit #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .address      (address),
        .in_data      (in_data),
        .out_data     (out_data),
        .hit          (hit),
        .PortIn       (PortIn),
        .PortOut      (PortOut),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovf  = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        address      = a;
        in_data      = d;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        address     = a;
        read_enable = 1'b1;
        #1;
        d           = out_data;
        read_enable = 1'b0;
    endtask

    // Push with tx_ready low: the model accepts while there is room.
    task automatic push_byte(input logic [7:0] b);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else                      exp_ovf = 1'b1;
        bus_write(BASE + 32'h0C, {24'd0, b});
    endtask

    // Drain with tx_ready high, comparing every handed-out byte.
    task automatic drain(input string tag);
        logic [7:0] e;
        int budget;
        budget   = 20;
        tx_ready = 1'b1;
        while (exp_q.size() > 0 && budget > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (tx_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL %s tx_valid: got %b expected 1", tag, tx_valid);
            end
            n_checks++;
            if (tx_data !== e) begin
                n_fail++;
                $display("FAIL %s tx_data: got %h expected %h", tag, tx_data, e);
            end
            tick();
            budget--;
        end
        tx_ready = 1'b0;
        n_checks++;
        if (tx_valid !== 1'b0 || budget == 0) begin
            n_fail++;
            $display("FAIL %s drained tx_valid: got %b expected 0 (budget %0d)", tag, tx_valid, budget);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b0; read_enable = 1'b0; write_enable = 1'b0;
        address = 32'd0; in_data = 32'd0; tx_ready = 1'b0; PortIn = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (PortOut !== 32'd0) begin n_fail++; $display("FAIL reset PortOut: got %h expected 0", PortOut); end
        n_checks++;
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset tx_valid: got %b expected 0", tx_valid); end
        n_checks++;
        if (tx_data !== 8'd0) begin n_fail++; $display("FAIL reset tx_data: got %h expected 0", tx_data); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset irq: got %b expected 0", irq); end
        reset = 1'b1;
        tick();
        bus_read(BASE + 32'h04, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL reset port_in_e1: got %h expected 0", d); end
        tick();
        bus_read(BASE + 32'h04, d);
        n_checks++;
        if (d !== 32'h0000_00A5) begin n_fail++; $display("FAIL reset port_in_e2: got %h expected a5", d); end
        bus_read(BASE + 32'h08, d);
        n_checks++;
        if (d !== 32'h4) begin n_fail++; $display("FAIL reset status_e2: got %h expected 4", d); end
        tick();
        bus_read(BASE + 32'h08, d);
        n_checks++;
        if (d !== 32'h5) begin n_fail++; $display("FAIL reset status_e3: got %h expected 5", d); end
        bus_write(BASE + 32'h08, 32'h1);
        bus_read(BASE + 32'h08, d);
        n_checks++;
        if (d !== 32'h4) begin n_fail++; $display("FAIL reset chg_clear: got %h expected 4", d); end
    endtask

    task automatic test_port_out();
        logic [31:0] d;
        bus_write(BASE, 32'hDEAD_BEEF);
        n_checks++;
        if (PortOut !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL port_out store: got %h expected deadbeef", PortOut); end
        bus_read(BASE, d);
        n_checks++;
        if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL port_out load: got %h expected deadbeef", d); end
        bus_read(BASE + 32'h03, d);
        n_checks++;
        if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL port_out byte_lane: got %h expected deadbeef", d); end
        address = 32'h1001_0000; in_data = 32'h1234_5678; write_enable = 1'b1;
        #1;
        n_checks++;
        if (hit !== 1'b0) begin n_fail++; $display("FAIL port_out miss_hit: got %b expected 0", hit); end
        tick();
        write_enable = 1'b0;
        n_checks++;
        if (PortOut !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL port_out miss_store: got %h expected deadbeef", PortOut); end
        address = BASE; in_data = 32'hCAFE_0001; write_enable = 1'b1; read_enable = 1'b1;
        #1;
        n_checks++;
        if (out_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL port_out rw_prewrite: got %h expected deadbeef", out_data); end
        tick();
        write_enable = 1'b0; read_enable = 1'b0;
        n_checks++;
        if (PortOut !== 32'hCAFE_0001) begin n_fail++; $display("FAIL port_out rw_store: got %h expected cafe0001", PortOut); end
        bus_write(BASE + 32'h04, 32'hFF);
        bus_read(BASE + 32'h04, d);
        n_checks++;
        if (d !== 32'hA5) begin n_fail++; $display("FAIL port_in ro: got %h expected a5", d); end
        bus_read(BASE + 32'h14, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL unused load: got %h expected 0", d); end
        bus_read(BASE + 32'h0C, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL tx_data load: got %h expected 0", d); end
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] d;
        logic [7:0]  bytes [5];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_byte(bytes[i]);
            if (i == 3) begin
                bus_read(BASE + 32'h08, d);
                n_checks++;
                if (d !== 32'h2) begin n_fail++; $display("FAIL overflow full: got %h expected 2", d); end
            end
        end
        bus_read(BASE + 32'h08, d);
        n_checks++;
        if (d !== {28'd0, exp_ovf, 3'b010}) begin n_fail++; $display("FAIL overflow status: got %h expected %h", d, {28'd0, exp_ovf, 3'b010}); end
        tick();
        n_checks++;
        if (tx_data !== 8'h11) begin n_fail++; $display("FAIL overflow head_stable: got %h expected 11", tx_data); end
        drain("overflow");
        exp_ovf = 1'b0;
        bus_write(BASE + 32'h08, 32'h8);
        bus_read(BASE + 32'h08, d);
        n_checks++;
        if (d !== 32'h4) begin n_fail++; $display("FAIL overflow ovf_clear: got %h expected 4", d); end
    endtask

    task automatic test_full_boundary();
        logic [31:0] d;
        logic [7:0]  e;
        for (int i = 1; i <= 4; i++) push_byte(i[7:0]);
        address = BASE + 32'h0C; in_data = 32'h66; write_enable = 1'b1; tx_ready = 1'b1;
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== e) begin n_fail++; $display("FAIL boundary head: got %b/%h expected 1/%h", tx_valid, tx_data, e); end
        exp_q.push_back(8'h66);
        tick();
        write_enable = 1'b0; tx_ready = 1'b0;
        bus_read(BASE + 32'h08, d);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL boundary status: got %h expected 2", d); end
        drain("boundary");
        // Push and ready together on an empty FIFO: push lands, nothing pops.
        tx_ready = 1'b1;
        bus_write(BASE + 32'h0C, 32'hAB);
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hAB) begin n_fail++; $display("FAIL empty_pushpop: got %b/%h expected 1/ab", tx_valid, tx_data); end
        tick();
        tx_ready = 1'b0;
        n_checks++;
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL empty_pushpop drained: got %b expected 0", tx_valid); end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] d;
        for (int i = 0; i < 5; i++) push_byte(8'h71 + i[7:0]);
        PortIn = 8'h5A;
        tick();
        tick();
        bus_write(BASE + 32'h08, 32'h1);
        bus_read(BASE + 32'h08, d);
        n_checks++;
        if (d !== 32'hB) begin n_fail++; $display("FAIL w1c collision: got %h expected b", d); end
        bus_write(BASE + 32'h08, 32'h9);
        exp_ovf = 1'b0;
        bus_read(BASE + 32'h08, d);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL w1c clear_both: got %h expected 2", d); end
        drain("w1c");
    endtask

    task automatic test_irq();
        logic [31:0] d;
`ifdef MMIO_IRQ_EN
        bus_write(BASE + 32'h10, 32'h1);
        bus_read(BASE + 32'h10, d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL irq irq_en_rb: got %h expected 1", d); end
        PortIn = 8'h3C;
        tick(); tick(); tick();
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq at_chg_edge: got %b expected 0", irq); end
        tick();
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq after_chg: got %b expected 1", irq); end
        bus_write(BASE + 32'h08, 32'h1);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq at_clear_edge: got %b expected 1", irq); end
        tick();
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq after_clear: got %b expected 0", irq); end
        bus_write(BASE + 32'h10, 32'h0);
`else
        bus_read(BASE + 32'h10, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL irq off_reg: got %h expected 0", d); end
        bus_write(BASE + 32'h10, 32'h3);
        PortIn = 8'h3C;
        repeat (4) tick();
        bus_read(BASE + 32'h08, d);
        n_checks++;
        if (d !== 32'h5) begin n_fail++; $display("FAIL irq off_status: got %h expected 5", d); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq off_level: got %b expected 0", irq); end
        bus_write(BASE + 32'h08, 32'h1);
`endif
        bus_read(BASE + 32'h08, d);
        n_checks++;
        if (d !== 32'h4) begin n_fail++; $display("FAIL irq chg_cleared: got %h expected 4", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        push_byte(8'h81);
        push_byte(8'h82);
        bus_write(BASE, 32'h55);
        tx_ready = 1'b1;
        reset    = 1'b0;
        #1;
        n_checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'd0) begin n_fail++; $display("FAIL reset_mid fifo: got %b/%h expected 0/00", tx_valid, tx_data); end
        n_checks++;
        if (PortOut !== 32'd0) begin n_fail++; $display("FAIL reset_mid PortOut: got %h expected 0", PortOut); end
        exp_q.delete();
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid after_release: got %b expected 0", tx_valid); end
        tx_ready = 1'b0;
        repeat (3) tick();
        bus_write(BASE + 32'h08, 32'h1);
        bus_read(BASE + 32'h08, d);
        n_checks++;
        if (d !== 32'h4) begin n_fail++; $display("FAIL reset_mid status: got %h expected 4", d); end
    endtask

    initial begin
        test_reset();
        test_port_out();
        test_fifo_overflow();
        test_full_boundary();
        test_w1c_collision();
        test_irq();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
